bitserial_mac_sequencer: RTL and testbench
==========================================

Name: bitserial_mac_sequencer

Overview:
Sequences the team's 8-bit bit-serial MAC unit over a vector of activation/weight pairs and accumulates the signed products into a dot-product result. It accepts operand pairs over a valid/ready stream and holds each pair stable on the MAC inputs. It gates the MAC enable for exactly the number of cycles set by the selected precision, then captures and sign-extends each 16-bit product and emits the accumulated sum on a valid/ready output.

Parameters:
ACC_W, 24, accumulator and result width in bits (must be >= 16)
LEN_W, 8, width of vector-length field

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset; synchronous, active-low
start  in  1  begin a vector; sampled only in IDLE
cfg_prec  in  2  precision level; 00 = 8 bit-cycles, 01 = 4, 10 = 2, 11 = treated as 01
cfg_len  in  LEN_W  number of pairs in vector; latched with start
busy  out  1  high in any state other than IDLE
in_valid  in  1  operand pair valid
in_act  in  8  activation operand
in_wgt  in  8  weight operand
in_ready  out  1  high only in LOAD
mac_rstn  out  1  MAC clear, active-low; low in IDLE, high otherwise
mac_en  out  1  MAC enable; high only in RUN
mac_prec  out  2  latched precision to MAC (11 is driven as 01)
mac_act  out  8  held activation
mac_wgt  out  8  held weight
mac_product  in  16  MAC product register (two's complement)
out_valid  out  1  result valid; high only in DONE
out_data  out  ACC_W  accumulated dot product
out_ready  in  1  result consumer ready

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE.
  - All registers clear: acc, pairs_left, bitcnt, prec_q, act/wgt holds.
  - Outputs: busy=0, in_ready=0, mac_en=0, mac_rstn=0, mac_act=mac_wgt=0, mac_prec=00, out_valid=0, out_data=0.
- L = 8/4/2 for prec_q = 00/01/10.
- IDLE:
  - mac_rstn=0 holds the MAC counter and product at 0.
  - On start=1: latch prec_q (11 stored as 01), pairs_left=cfg_len, acc=0.
  - cfg_len=0 -> DONE; otherwise -> LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid: latch in_act/in_wgt into the holds, bitcnt=0, -> RUN.
  - Without in_valid: stay; mac_en stays 0.
- RUN:
  - mac_en=1; bitcnt increments each cycle.
  - When bitcnt==L-1: -> CAPTURE. RUN therefore lasts exactly L cycles.
  - Operand holds do not change during RUN.
- CAPTURE (one cycle, mac_en=0):
  - acc <= acc + sign_extend(mac_product, ACC_W), wrapping modulo 2^ACC_W.
  - pairs_left decrements.
  - pairs_left==1 before the decrement -> DONE; otherwise -> LOAD.
  - The MAC counter is not cleared between pairs. Alignment relies on exactly L enables per pair.
- DONE:
  - out_valid=1, out_data=acc; both held stable until out_ready.
  - out_valid & out_ready -> IDLE.
  - out_data retains its value after the handshake until the next start.
- Per-pair latency: 1 (LOAD with in_valid) + L (RUN) + 1 (CAPTURE) cycles.
- Vector latency: N*(L+2) cycles + 1 to DONE, with no input stalls.
- start outside IDLE is ignored. cfg_* changes outside IDLE have no effect.
- Reset mid-operation (any state): abort immediately to the reset values. Partial acc is discarded and no out_valid is produced. mac_rstn=0 in IDLE re-aligns the MAC.
- in_valid in any state but LOAD is ignored; no pair is consumed.
- Accumulator overflow wraps silently; there is no saturation or flag.

Test Plan:
1. 8-bit, len=1, pair (0x67, 0x0A): 8 mac_en cycles, then CAPTURE. Require mac_product=0x0406 and out_data=0x000406.
2. 8-bit, len=2, pairs (0x67, 0x0A) then (0x3F, 0xE1): require out_data=0xFFFC65 (1030 - 1953 = -923) and total cycles start->out_valid = 2*10+1.
3. prec=01, then prec=11, len=3, in_valid always high: require exactly 4 mac_en pulses per pair in both runs and mac_prec=01 in both; in_ready pulses once per pair.
4. len=0: out_valid asserted the cycle after start with out_data=0, and no mac_en pulse.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE; out_valid/out_data stay stable and start pulses are ignored. Release, then IDLE next cycle.
6. Reset: assert rstn=0 during RUN of pair 2 of 3; next edge shows all outputs at reset values. A new len=1 vector (0x67, 0x0A) then yields 0x000406.

Source files
------------

// File: rtl/bitserial_mac_sequencer_if.sv
// bitserial_mac_sequencer_if: stream, config and MAC-side signals of the sequencer.
// master is the environment (operand source, MAC, result sink); slave is the sequencer.
interface bitserial_mac_sequencer_if #(parameter int ACC_W = 24, parameter int LEN_W = 8);
   logic             start;
   logic [1:0]       cfg_prec;
   logic [LEN_W-1:0] cfg_len;
   logic             busy;
   logic             in_valid;
   logic [7:0]       in_act;
   logic [7:0]       in_wgt;
   logic             in_ready;
   logic             mac_rstn;
   logic             mac_en;
   logic [1:0]       mac_prec;
   logic [7:0]       mac_act;
   logic [7:0]       mac_wgt;
   logic [15:0]      mac_product;
   logic             out_valid;
   logic [ACC_W-1:0] out_data;
   logic             out_ready;
   modport master (
      output start, cfg_prec, cfg_len, in_valid, in_act, in_wgt, mac_product, out_ready,
      input  busy, in_ready, mac_rstn, mac_en, mac_prec, mac_act, mac_wgt, out_valid, out_data
   );
   modport slave (
      input  start, cfg_prec, cfg_len, in_valid, in_act, in_wgt, mac_product, out_ready,
      output busy, in_ready, mac_rstn, mac_en, mac_prec, mac_act, mac_wgt, out_valid, out_data
   );
endinterface

// File: rtl/bitserial_mac_sequencer.sv
// bitserial_mac_sequencer: drives a bit-serial MAC over a vector of operand pairs
// and accumulates the sign-extended products into a dot product.
module bitserial_mac_sequencer #(parameter int ACC_W = 24, parameter int LEN_W = 8) (
   input logic clk,
   input logic rstn,
   bitserial_mac_sequencer_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPTURE, S_DONE} state_t;
   state_t           r_state, w_next;
   logic [ACC_W-1:0] r_acc;
   logic [LEN_W-1:0] r_pairs_left;
   logic [2:0]       r_bitcnt;
   logic [1:0]       r_prec;
   logic [7:0]       r_act, r_wgt;
   logic [2:0]       w_last;
   logic [ACC_W-1:0] w_prod_ext;
   assign w_last     = r_prec == 2'b00 ? 3'd7 : r_prec == 2'b01 ? 3'd3 : 3'd1;
   assign w_prod_ext = ACC_W'($signed(bus.mac_product));
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_acc        <= '0;
         r_pairs_left <= '0;
         r_bitcnt     <= '0;
         r_prec       <= '0;
         r_act        <= '0;
         r_wgt        <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: if (bus.start) begin
               r_prec       <= bus.cfg_prec == 2'b11 ? 2'b01 : bus.cfg_prec;
               r_pairs_left <= bus.cfg_len;
               r_acc        <= '0;
            end
            S_LOAD: if (bus.in_valid) begin
               r_act    <= bus.in_act;
               r_wgt    <= bus.in_wgt;
               r_bitcnt <= '0;
            end
            S_RUN: r_bitcnt <= r_bitcnt + 3'd1;
            S_CAPTURE: begin
               r_acc        <= r_acc + w_prod_ext;
               r_pairs_left <= r_pairs_left - LEN_W'(1);
            end
            default: ;
         endcase
      end
   end
   // The MAC counter is never cleared between pairs, so RUN must last exactly L cycles.
   always_comb begin
      w_next        = r_state;
      bus.busy      = r_state != S_IDLE;
      bus.in_ready  = r_state == S_LOAD;
      bus.mac_rstn  = r_state != S_IDLE;
      bus.mac_en    = r_state == S_RUN;
      bus.out_valid = r_state == S_DONE;
      bus.mac_prec  = r_prec;
      bus.mac_act   = r_act;
      bus.mac_wgt   = r_wgt;
      bus.out_data  = r_acc;
      case (r_state)
         S_IDLE:    if (bus.start) w_next = bus.cfg_len == '0 ? S_DONE : S_LOAD;
         S_LOAD:    if (bus.in_valid) w_next = S_RUN;
         S_RUN:     if (r_bitcnt == w_last) w_next = S_CAPTURE;
         S_CAPTURE: w_next = r_pairs_left == LEN_W'(1) ? S_DONE : S_LOAD;
         S_DONE:    if (bus.out_ready) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_bitserial_mac_sequencer.sv
// tb_bitserial_mac_sequencer: directed bench with a behavioural bit-serial MAC model.
module tb_bitserial_mac_sequencer;
   logic clk, rstn;
   int tests = 0, fails = 0;
   bitserial_mac_sequencer_if #(.ACC_W(24), .LEN_W(8)) bus ();
   bitserial_mac_sequencer #(.ACC_W(24), .LEN_W(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   initial clk = 0;
   always #5 clk = ~clk;

   // MAC model: product register loads act*wgt after every L enables; counter only cleared by mac_rstn.
   logic [2:0] m_cnt;
   int m_len;
   assign m_len = bus.mac_prec == 2'b00 ? 8 : bus.mac_prec == 2'b01 ? 4 : 2;
   always @(posedge clk) begin
      if (!bus.mac_rstn) begin
         m_cnt <= 0;
         bus.mac_product <= 16'h0;
      end else if (bus.mac_en) begin
         if (int'(m_cnt) == m_len - 1) begin
            m_cnt <= 0;
            bus.mac_product <= $signed(bus.mac_act) * $signed(bus.mac_wgt);
         end else m_cnt <= m_cnt + 3'd1;
      end
   end

   int en_total = 0, ready_total = 0, run_len = 0;
   int runs[$];
   logic prev_en = 0;
   logic [15:0] cap_prod = 0;
   always @(negedge clk) begin
      if (bus.mac_en) begin
         en_total++;
         run_len++;
      end else if (run_len != 0) begin
         runs.push_back(run_len);
         run_len = 0;
      end
      if (bus.in_ready) ready_total++;
      if (!bus.mac_en && prev_en) cap_prod = bus.mac_product;
      prev_en = bus.mac_en;
   end

   logic [7:0] pa[8], pw[8];
   int k, ens, rdys, cyc;

   task automatic feed_cycle();
      logic hs;
      hs = bus.in_ready & bus.in_valid;
      @(negedge clk);
      bus.start = 0;
      if (hs) begin
         k++;
         bus.in_act = pa[k % 8];
         bus.in_wgt = pw[k % 8];
      end
   endtask

   task automatic begin_vec(input logic [1:0] p, input int n);
      @(negedge clk);
      bus.cfg_prec = p;
      bus.cfg_len = 8'(n);
      bus.start = 1;
      k = 0;
      bus.in_act = pa[0];
      bus.in_wgt = pw[0];
      bus.in_valid = 1;
      runs.delete();
   endtask

   task automatic run_vec(input logic [1:0] p, input int n);
      int e0, r0;
      begin_vec(p, n);
      e0 = en_total;
      r0 = ready_total;
      cyc = 0;
      while (!bus.out_valid && cyc < 400) begin
         feed_cycle();
         cyc++;
      end
      bus.in_valid = 0;
      ens = en_total - e0;
      rdys = ready_total - r0;
   endtask

   task automatic finish_out();
      bus.out_ready = 1;
      @(negedge clk);
      bus.out_ready = 0;
      tests++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL idle_after_handshake: busy=%b out_valid=%b expected 0/0", bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_reset();
      rstn = 0;
      repeat (3) @(negedge clk);
      tests++;
      if ({bus.busy, bus.in_ready, bus.mac_en, bus.mac_rstn, bus.out_valid, bus.mac_prec,
           bus.mac_act, bus.mac_wgt, bus.out_data} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: busy=%b rdy=%b en=%b mrstn=%b ov=%b prec=%b act=%h wgt=%h data=%h expected all 0",
                  bus.busy, bus.in_ready, bus.mac_en, bus.mac_rstn, bus.out_valid, bus.mac_prec,
                  bus.mac_act, bus.mac_wgt, bus.out_data);
      end
      rstn = 1;
   endtask

   task automatic test_single();
      pa[0] = 8'h67; pw[0] = 8'h0A;
      run_vec(2'b00, 1);
      tests++;
      if (bus.out_data !== 24'h000406) begin
         fails++; $display("FAIL single_data: got %h expected 000406", bus.out_data);
      end
      tests++;
      if (cap_prod !== 16'h0406) begin
         fails++; $display("FAIL single_product: got %h expected 0406", cap_prod);
      end
      tests++;
      if (runs.size() != 1 || ens != 8) begin
         fails++; $display("FAIL single_en_pulses: runs=%0d en=%0d expected 1 run of 8", runs.size(), ens);
      end
      tests++;
      if (cyc != 11) begin
         fails++; $display("FAIL single_latency: got %0d expected 11", cyc);
      end
      finish_out();
   endtask

   task automatic test_two_pairs();
      pa[0] = 8'h67; pw[0] = 8'h0A;
      pa[1] = 8'h3F; pw[1] = 8'hE1;
      run_vec(2'b00, 2);
      tests++;
      if (bus.out_data !== 24'hFFFC65) begin
         fails++; $display("FAIL two_pairs_data: got %h expected fffc65", bus.out_data);
      end
      tests++;
      if (cyc != 21) begin
         fails++; $display("FAIL two_pairs_latency: got %0d expected 21", cyc);
      end
      tests++;
      if (ens != 16) begin
         fails++; $display("FAIL two_pairs_en: got %0d expected 16", ens);
      end
      finish_out();
   endtask

   task automatic test_prec(input logic [1:0] p);
      pa[0] = 8'h12; pw[0] = 8'h03;
      pa[1] = 8'hF0; pw[1] = 8'h05;
      pa[2] = 8'h7F; pw[2] = 8'h7F;
      run_vec(p, 3);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (runs.size() <= i || runs[i] != 4) begin
            fails++; $display("FAIL prec%b_run%0d: got %0d expected 4", p, i, runs.size() > i ? runs[i] : -1);
         end
      end
      tests++;
      if (bus.mac_prec !== 2'b01) begin
         fails++; $display("FAIL prec%b_mac_prec: got %b expected 01", p, bus.mac_prec);
      end
      tests++;
      if (rdys != 3 || cyc != 19) begin
         fails++; $display("FAIL prec%b_ready_latency: ready=%0d cyc=%0d expected 3/19", p, rdys, cyc);
      end
      finish_out();
   endtask

   task automatic test_len_zero();
      run_vec(2'b00, 0);
      tests++;
      if (bus.out_valid !== 1'b1 || cyc != 1) begin
         fails++; $display("FAIL len0_latency: ov=%b cyc=%0d expected 1/1", bus.out_valid, cyc);
      end
      tests++;
      if (bus.out_data !== 24'h0 || ens != 0) begin
         fails++; $display("FAIL len0_data: data=%h en=%0d expected 0/0", bus.out_data, ens);
      end
      finish_out();
   endtask

   task automatic test_backpressure();
      pa[0] = 8'h80; pw[0] = 8'h7F;
      run_vec(2'b00, 1);
      tests++;
      if (bus.out_data !== 24'hFFC080) begin
         fails++; $display("FAIL bp_data: got %h expected ffc080", bus.out_data);
      end
      bus.cfg_len = 8'd5;
      bus.cfg_prec = 2'b10;
      for (int i = 0; i < 5; i++) begin
         bus.start = 1;
         @(negedge clk);
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 24'hFFC080 || bus.mac_en !== 1'b0) begin
            fails++; $display("FAIL bp_hold%0d: ov=%b data=%h en=%b expected 1/ffc080/0", i, bus.out_valid, bus.out_data, bus.mac_en);
         end
      end
      bus.start = 0;
      finish_out();
      tests++;
      if (bus.out_data !== 24'hFFC080) begin
         fails++; $display("FAIL bp_retain: got %h expected ffc080", bus.out_data);
      end
   endtask

   task automatic test_reset_midrun();
      int n;
      pa[0] = 8'h67; pw[0] = 8'h0A;
      pa[1] = 8'h3F; pw[1] = 8'hE1;
      pa[2] = 8'h11; pw[2] = 8'h22;
      begin_vec(2'b00, 3);
      n = 0;
      while (!(k == 2 && bus.mac_en) && n < 100) begin
         feed_cycle();
         n++;
      end
      tests++;
      if (n >= 100) begin
         fails++; $display("FAIL midrun_reach: never reached RUN of pair 2 (k=%0d)", k);
      end
      rstn = 0;
      @(negedge clk);
      tests++;
      if ({bus.busy, bus.in_ready, bus.mac_en, bus.mac_rstn, bus.out_valid, bus.mac_prec,
           bus.mac_act, bus.mac_wgt, bus.out_data} !== '0) begin
         fails++;
         $display("FAIL midrun_reset_outputs: busy=%b en=%b mrstn=%b ov=%b act=%h wgt=%h data=%h expected all 0",
                  bus.busy, bus.mac_en, bus.mac_rstn, bus.out_valid, bus.mac_act, bus.mac_wgt, bus.out_data);
      end
      rstn = 1;
      bus.in_valid = 0;
      pa[0] = 8'h67; pw[0] = 8'h0A;
      run_vec(2'b00, 1);
      tests++;
      if (bus.out_data !== 24'h000406 || cyc != 11) begin
         fails++; $display("FAIL midrun_recover: data=%h cyc=%0d expected 000406/11", bus.out_data, cyc);
      end
      finish_out();
   endtask

   initial begin
      rstn = 0;
      bus.start = 0; bus.cfg_prec = 0; bus.cfg_len = 0;
      bus.in_valid = 0; bus.in_act = 0; bus.in_wgt = 0; bus.out_ready = 0;
      for (int i = 0; i < 8; i++) begin pa[i] = 0; pw[i] = 0; end
      test_reset();
      test_single();
      test_two_pairs();
      test_prec(2'b01);
      test_prec(2'b11);
      test_len_zero();
      test_backpressure();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
